// File: rtl/tft_pkg.sv
// rtl/tft_pkg.sv - shared ILI9341 constants and TFT serializer state encoding
package tft_pkg;

  localparam logic [7:0] CASET = 8'h2a;
  localparam logic [7:0] PASET = 8'h2b;
  localparam logic [7:0] RAMWR = 8'h2c;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_LINGER = 2'd3
  } tx_state_e;

endpackage

// File: rtl/spi_tick.sv
// rtl/spi_tick.sv - SCK half-period counter, one-cycle tick every clk_div enabled cycles
module spi_tick #(
  parameter int clk_div = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = $clog2(clk_div + 1);

  logic [W-1:0] div_cnt_q, div_cnt_d;

  assign tick = en && (div_cnt_q == W'(clk_div - 1));

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clr) begin
      div_cnt_d = '0;
    end else if (en) begin
      div_cnt_d = tick ? '0 : div_cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/tft_spi_tx.sv
// rtl/tft_spi_tx.sv - byte strobe to 4-wire SPI mode 0 serializer for the ILI9341 panel
module tft_spi_tx
  import tft_pkg::*;
#(
  parameter int clk_div = 2,
  parameter int cs_idle = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tft_transmit,
  input  logic       tft_dc,
  input  logic [7:0] tft_data,
  output logic       tft_busy,
  output logic       lcd_cs,
  output logic       lcd_dc,
  output logic       lcd_sck,
  output logic       lcd_mosi
);

  localparam int LW = $clog2(cs_idle + 1);

  tx_state_e     state_q, state_d;
  logic          busy_q, busy_d;
  logic          cs_q, cs_d;
  logic          dc_q, dc_d;
  logic          sck_q, sck_d;
  logic          mosi_q, mosi_d;
  logic [7:0]    data_q, data_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [2:0]    bit_nxt;
  logic [LW-1:0] linger_cnt_q, linger_cnt_d;

  logic accept;
  logic tick;
  logic tick_en;
  logic linger_done;
  logic last_bit_done;

  assign accept        = tft_transmit && !busy_q &&
                         (state_q == ST_IDLE || state_q == ST_LINGER);
  assign tick_en       = (state_q == ST_SETUP) || (state_q == ST_SHIFT);
  assign linger_done   = (state_q == ST_LINGER) && (linger_cnt_q == LW'(cs_idle - 1));
  assign last_bit_done = (state_q == ST_SHIFT) && tick && sck_q && (bit_cnt_q == 3'd0);
  assign bit_nxt       = bit_cnt_q - 3'd1;

  spi_tick #(.clk_div(clk_div)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (tick_en),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      cs_q         <= 1'b1;
      dc_q         <= 1'b1;
      sck_q        <= 1'b0;
      mosi_q       <= 1'b0;
      data_q       <= '0;
      bit_cnt_q    <= '0;
      linger_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      cs_q         <= cs_d;
      dc_q         <= dc_d;
      sck_q        <= sck_d;
      mosi_q       <= mosi_d;
      data_q       <= data_d;
      bit_cnt_q    <= bit_cnt_d;
      linger_cnt_q <= linger_cnt_d;
    end
  end

  // A byte arriving in LINGER skips SETUP since CS is already low.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_SETUP;
      ST_SETUP:  if (tick) state_d = ST_SHIFT;
      ST_SHIFT:  if (last_bit_done) state_d = ST_LINGER;
      ST_LINGER: begin
        if (accept) begin
          state_d = ST_SHIFT;
        end else if (linger_done) begin
          state_d = ST_IDLE;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_d       = busy_q;
    cs_d         = cs_q;
    dc_d         = dc_q;
    sck_d        = sck_q;
    mosi_d       = mosi_q;
    data_d       = data_q;
    bit_cnt_d    = bit_cnt_q;
    linger_cnt_d = linger_cnt_q;
    if (accept) begin
      data_d       = tft_data;
      busy_d       = 1'b1;
      cs_d         = 1'b0;
      dc_d         = tft_dc;
      mosi_d       = tft_data[7];
      sck_d        = 1'b0;
      bit_cnt_d    = 3'd7;
      linger_cnt_d = '0;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          if (tick) begin
            if (!sck_q) begin
              sck_d = 1'b1;
            end else begin
              // Falling edge: present the next bit, or finish the byte.
              sck_d = 1'b0;
              if (bit_cnt_q != 3'd0) begin
                bit_cnt_d = bit_nxt;
                mosi_d    = data_q[bit_nxt];
              end else begin
                busy_d       = 1'b0;
                linger_cnt_d = '0;
              end
            end
          end
        end
        ST_LINGER: begin
          if (linger_done) begin
            cs_d         = 1'b1;
            linger_cnt_d = '0;
          end else begin
            linger_cnt_d = linger_cnt_q + LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign tft_busy = busy_q;
  assign lcd_cs   = cs_q;
  assign lcd_dc   = dc_q;
  assign lcd_sck  = sck_q;
  assign lcd_mosi = mosi_q;

endmodule

// File: tb/tb_tft_spi_tx.sv
// tb/tb_tft_spi_tx.sv - scoreboard bench for tft_spi_tx at clk_div=2 and clk_div=1
module tb_tft_spi_tx;
  import tft_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx0 = 1'b0, dc0 = 1'b0;
  logic [7:0] d0  = 8'h00;
  logic       tx1 = 1'b0, dc1 = 1'b0;
  logic [7:0] d1  = 8'h00;
  logic       busy0, cs0, ldc0, sck0, mosi0;
  logic       busy1, cs1, ldc1, sck1, mosi1;

  int checks = 0;
  int fails  = 0;
  logic [8:0] exp0[$];
  logic [8:0] exp1[$];
  int rise0 = 0;
  int rise1 = 0;
  bit allow0 = 1'b0;

  always #5 clk = ~clk;

  tft_spi_tx #(.clk_div(2), .cs_idle(4)) dut (
    .clk(clk), .rst(rst), .tft_transmit(tx0), .tft_dc(dc0), .tft_data(d0),
    .tft_busy(busy0), .lcd_cs(cs0), .lcd_dc(ldc0), .lcd_sck(sck0), .lcd_mosi(mosi0)
  );

  tft_spi_tx #(.clk_div(1), .cs_idle(4)) dut1 (
    .clk(clk), .rst(rst), .tft_transmit(tx1), .tft_dc(dc1), .tft_data(d1),
    .tft_busy(busy1), .lcd_cs(cs1), .lcd_dc(ldc1), .lcd_sck(sck1), .lcd_mosi(mosi1)
  );

  // Panel-side capture for the clk_div=2 instance.
  logic [7:0] sh0 = 8'h00;
  logic [8:0] e0;
  int nb0 = 0;
  logic sck0_prev = 1'b0, dc0_prev = 1'b1;
  always @(negedge clk) begin
    if (rst) begin
      nb0 = 0;
    end else begin
      if (sck0 && !sck0_prev) begin
        rise0++;
        sh0 = {sh0[6:0], mosi0};
        nb0++;
        checks++;
        if (cs0 !== 1'b0) begin
          fails++; $display("FAIL cs0_at_rise: lcd_cs=%b required 0", cs0);
        end
        if (exp0.size() > 0) begin
          checks++;
          if (ldc0 !== exp0[0][8]) begin
            fails++; $display("FAIL dc0_at_rise: lcd_dc=%b required %b", ldc0, exp0[0][8]);
          end
        end
        if (nb0 == 8) begin
          nb0 = 0;
          checks++;
          if (exp0.size() == 0) begin
            fails++; $display("FAIL byte0_unexpected: got dc=%b data=%h, none required", ldc0, sh0);
          end else begin
            e0 = exp0.pop_front();
            if ({ldc0, sh0} !== e0) begin
              fails++; $display("FAIL byte0: got dc=%b data=%h required dc=%b data=%h", ldc0, sh0, e0[8], e0[7:0]);
            end
          end
        end
      end
      if (ldc0 !== dc0_prev) begin
        checks++;
        if (sck0 !== 1'b0) begin
          fails++; $display("FAIL dc0_change_sck_high: lcd_sck=%b required 0", sck0);
        end
      end
      if (tx0 && busy0) begin
        checks++;
        if (!allow0) begin
          fails++; $display("FAIL protocol0: strobe while busy got 1 required 0");
        end
      end
    end
    sck0_prev = sck0;
    dc0_prev  = ldc0;
  end

  logic [7:0] sh1 = 8'h00;
  logic [8:0] e1;
  int nb1 = 0;
  logic sck1_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      nb1 = 0;
    end else if (sck1 && !sck1_prev) begin
      rise1++;
      sh1 = {sh1[6:0], mosi1};
      nb1++;
      if (nb1 == 8) begin
        nb1 = 0;
        checks++;
        if (exp1.size() == 0) begin
          fails++; $display("FAIL byte1_unexpected: got dc=%b data=%h, none required", ldc1, sh1);
        end else begin
          e1 = exp1.pop_front();
          if ({ldc1, sh1} !== e1) begin
            fails++; $display("FAIL byte1: got dc=%b data=%h required dc=%b data=%h", ldc1, sh1, e1[8], e1[7:0]);
          end
        end
      end
    end
    sck1_prev = sck1;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic strobe0(input logic dc, input logic [7:0] d);
    tx0 = 1'b1; dc0 = dc; d0 = d;
    exp0.push_back({dc, d});
    step();
    tx0 = 1'b0;
  endtask

  task automatic strobe1(input logic dc, input logic [7:0] d);
    tx1 = 1'b1; dc1 = dc; d1 = d;
    exp1.push_back({dc, d});
    step();
    tx1 = 1'b0;
  endtask

  task automatic measure_busy0(output int n, output int cs_hi);
    n = 0; cs_hi = 0;
    while (busy0 && n < 400) begin
      step(); n++;
      if (cs0) cs_hi++;
    end
  endtask

  task automatic measure_busy1(output int n, output int cs_hi);
    n = 0; cs_hi = 0;
    while (busy1 && n < 400) begin
      step(); n++;
      if (cs1) cs_hi++;
    end
  endtask

  task automatic wait_cs_high0(output int m);
    m = 0;
    while (!cs0 && m < 100) begin
      step(); m++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks += 10;
    if (busy0 !== 1'b0) begin fails++; $display("FAIL rst_busy0: got %b required 0", busy0); end
    if (cs0   !== 1'b1) begin fails++; $display("FAIL rst_cs0: got %b required 1", cs0); end
    if (ldc0  !== 1'b1) begin fails++; $display("FAIL rst_dc0: got %b required 1", ldc0); end
    if (sck0  !== 1'b0) begin fails++; $display("FAIL rst_sck0: got %b required 0", sck0); end
    if (mosi0 !== 1'b0) begin fails++; $display("FAIL rst_mosi0: got %b required 0", mosi0); end
    if (busy1 !== 1'b0) begin fails++; $display("FAIL rst_busy1: got %b required 0", busy1); end
    if (cs1   !== 1'b1) begin fails++; $display("FAIL rst_cs1: got %b required 1", cs1); end
    if (ldc1  !== 1'b1) begin fails++; $display("FAIL rst_dc1: got %b required 1", ldc1); end
    if (sck1  !== 1'b0) begin fails++; $display("FAIL rst_sck1: got %b required 0", sck1); end
    if (mosi1 !== 1'b0) begin fails++; $display("FAIL rst_mosi1: got %b required 0", mosi1); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_byte();
    int n, ch, m, r;
    r = rise0;
    strobe0(DC_CMD, CASET);
    checks += 2;
    if (busy0 !== 1'b1) begin fails++; $display("FAIL single_busy_rise: got %b required 1", busy0); end
    if (ldc0 !== DC_CMD) begin fails++; $display("FAIL single_dc: got %b required 0", ldc0); end
    measure_busy0(n, ch);
    checks += 2;
    if (n != 34) begin fails++; $display("FAIL single_busy_len: got %0d required 34", n); end
    if (rise0 - r != 8) begin fails++; $display("FAIL single_rises: got %0d required 8", rise0 - r); end
    wait_cs_high0(m);
    checks += 2;
    if (m != 4) begin fails++; $display("FAIL single_cs_release: got %0d required 4", m); end
    if (exp0.size() != 0) begin fails++; $display("FAIL single_sb_left: got %0d required 0", exp0.size()); end
  endtask

  task automatic test_back_to_back();
    int n, ch, n2, ch2, m, r2;
    strobe0(DC_DATA, 8'h00);
    measure_busy0(n, ch);
    r2 = rise0;
    strobe0(DC_DATA, 8'hff);
    checks += 2;
    if (n != 34) begin fails++; $display("FAIL b2b_first_len: got %0d required 34", n); end
    if (cs0 !== 1'b0) begin fails++; $display("FAIL b2b_cs_gap: got %b required 0", cs0); end
    measure_busy0(n2, ch2);
    checks += 3;
    if (n2 != 32) begin fails++; $display("FAIL b2b_second_len: got %0d required 32", n2); end
    if (ch + ch2 != 0) begin fails++; $display("FAIL b2b_cs_high_cycles: got %0d required 0", ch + ch2); end
    if (rise0 - r2 != 8) begin fails++; $display("FAIL b2b_rises: got %0d required 8", rise0 - r2); end
    wait_cs_high0(m);
    checks += 2;
    if (m != 4) begin fails++; $display("FAIL b2b_cs_release: got %0d required 4", m); end
    if (exp0.size() != 0) begin fails++; $display("FAIL b2b_sb_left: got %0d required 0", exp0.size()); end
  endtask

  task automatic test_timeout_race();
    int n, ch, n2, ch2, m, r;
    strobe0(DC_DATA, 8'h3c);
    measure_busy0(n, ch);
    repeat (3) step();
    checks++;
    if (cs0 !== 1'b0) begin fails++; $display("FAIL race_cs_before: got %b required 0", cs0); end
    r = rise0;
    strobe0(DC_DATA, 8'ha5);
    checks++;
    if (cs0 !== 1'b0) begin fails++; $display("FAIL race_cs_at_timeout: got %b required 0", cs0); end
    measure_busy0(n2, ch2);
    checks += 3;
    if (n2 != 32) begin fails++; $display("FAIL race_busy_len: got %0d required 32", n2); end
    if (ch2 != 0) begin fails++; $display("FAIL race_cs_high_cycles: got %0d required 0", ch2); end
    if (rise0 - r != 8) begin fails++; $display("FAIL race_rises: got %0d required 8", rise0 - r); end
    wait_cs_high0(m);
    checks += 2;
    if (m != 4) begin fails++; $display("FAIL race_cs_release: got %0d required 4", m); end
    if (exp0.size() != 0) begin fails++; $display("FAIL race_sb_left: got %0d required 0", exp0.size()); end
  endtask

  task automatic test_protocol_violation();
    int n, m, r, r2;
    r = rise0;
    strobe0(DC_CMD, 8'h81);
    n = 0;
    while (busy0 && n < 400) begin
      if (n == 10) begin
        allow0 = 1'b1; tx0 = 1'b1; dc0 = DC_DATA; d0 = 8'h55;
      end
      step(); n++;
      if (n == 11) begin
        tx0 = 1'b0; allow0 = 1'b0;
      end
    end
    checks += 2;
    if (n != 34) begin fails++; $display("FAIL viol_busy_len: got %0d required 34", n); end
    if (rise0 - r != 8) begin fails++; $display("FAIL viol_rises: got %0d required 8", rise0 - r); end
    wait_cs_high0(m);
    r2 = rise0;
    repeat (20) step();
    checks += 4;
    if (m != 4) begin fails++; $display("FAIL viol_cs_release: got %0d required 4", m); end
    if (exp0.size() != 0) begin fails++; $display("FAIL viol_sb_left: got %0d required 0", exp0.size()); end
    if (rise0 != r2) begin fails++; $display("FAIL viol_extra_rises: got %0d required 0", rise0 - r2); end
    if (busy0 !== 1'b0) begin fails++; $display("FAIL viol_busy_after: got %b required 0", busy0); end
  endtask

  task automatic test_mid_byte_reset();
    int r;
    strobe0(DC_CMD, 8'hff);
    repeat (10) step();
    checks += 2;
    if (busy0 !== 1'b1) begin fails++; $display("FAIL midrst_busy_pre: got %b required 1", busy0); end
    if (mosi0 !== 1'b1) begin fails++; $display("FAIL midrst_mosi_pre: got %b required 1", mosi0); end
    rst = 1'b1;
    step();
    checks += 5;
    if (cs0   !== 1'b1) begin fails++; $display("FAIL midrst_cs: got %b required 1", cs0); end
    if (sck0  !== 1'b0) begin fails++; $display("FAIL midrst_sck: got %b required 0", sck0); end
    if (busy0 !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b required 0", busy0); end
    if (mosi0 !== 1'b0) begin fails++; $display("FAIL midrst_mosi: got %b required 0", mosi0); end
    if (ldc0  !== 1'b1) begin fails++; $display("FAIL midrst_dc: got %b required 1", ldc0); end
    rst = 1'b0;
    exp0.delete();
    r = rise0;
    repeat (40) step();
    checks += 2;
    if (rise0 != r) begin fails++; $display("FAIL midrst_extra_rises: got %0d required 0", rise0 - r); end
    if (cs0 !== 1'b1) begin fails++; $display("FAIL midrst_cs_after: got %b required 1", cs0); end
  endtask

  task automatic test_clk_div1_caset();
    logic [8:0] seq [11];
    int n, ch, cs_total, m;
    seq = '{{DC_CMD, CASET}, {DC_DATA, 8'h00}, {DC_DATA, 8'h10}, {DC_DATA, 8'h00}, {DC_DATA, 8'hef},
            {DC_CMD, PASET}, {DC_DATA, 8'h00}, {DC_DATA, 8'h20}, {DC_DATA, 8'h00}, {DC_DATA, 8'h3f},
            {DC_CMD, RAMWR}};
    cs_total = 0;
    for (int i = 0; i < 11; i++) begin
      strobe1(seq[i][8], seq[i][7:0]);
      measure_busy1(n, ch);
      cs_total += ch;
      checks++;
      if (n != ((i == 0) ? 17 : 16)) begin
        fails++; $display("FAIL div1_busy_len[%0d]: got %0d required %0d", i, n, (i == 0) ? 17 : 16);
      end
    end
    m = 0;
    while (!cs1 && m < 100) begin
      step(); m++;
    end
    checks += 3;
    if (cs_total != 0) begin fails++; $display("FAIL div1_cs_high_cycles: got %0d required 0", cs_total); end
    if (m != 4) begin fails++; $display("FAIL div1_cs_release: got %0d required 4", m); end
    if (exp1.size() != 0) begin fails++; $display("FAIL div1_sb_left: got %0d required 0", exp1.size()); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_timeout_race();
    test_protocol_violation();
    test_mid_byte_reset();
    test_clk_div1_caset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
